ps2_led_ctrl: RTL

Host-to-device command sequencer for the PS/2 keyboard port. It updates the keyboard LEDs by sending the two-byte command 0xED, mask. It takes the bus from the scan-code receiver, clocks each byte out on device-generated clocks, and checks the line-level ack bit. It then waits for the 0xFA acknowledge byte, which the existing receiver decodes. It sits beside the receiver, drives the open-drain clock/data enables, and gates the receiver while transmitting.

---
 rtl/ps2_led_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_led_ctrl.sv
// PS/2 host-to-device LED update: sends 0xED then {5'b0, mask} and tracks the keyboard's
// line-level ack bit and 0xFA/0xFE reply bytes, borrowing the bus from the scan-code receiver.
module ps2_led_ctrl #(
   parameter int INHIBIT_CYC = 10000,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       led_req,
   input  logic [2:0] led_mask,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       rx_hold
);

   localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = $clog2(MAX_RETRY + 2);

   localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRY);
   localparam logic [7:0]    CMD_LED    = 8'hED;
   localparam logic [7:0]    RSP_ACK    = 8'hFA;
   localparam logic [7:0]    RSP_RESEND = 8'hFE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_TX,
      S_WAIT_ACK,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic [2:0]    mask_q, mask_d;
   logic          pend_q, pend_d;
   logic [2:0]    pend_mask_q, pend_mask_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          clk_prev_q;

   logic [1:0]    raw_in;
   logic [1:0]    sync_out;
   logic          clk_sync;
   logic          data_sync;
   logic          fall;
   logic          tx_bit;
   logic          start;
   logic [2:0]    start_mask;

   // bit 0 = PS/2 clock, bit 1 = PS/2 data; both get the same two-stage synchroniser
   assign raw_in = {ps2_data_in, ps2_clk_in};

   for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_q;
      logic s2_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
         end else begin
            s1_q <= raw_in[gi];
            s2_q <= s1_q;
         end
      end
      assign sync_out[gi] = s2_q;
   end

   assign clk_sync  = sync_out[0];
   assign data_sync = sync_out[1];
   assign fall      = clk_prev_q & ~clk_sync;

   // Slot n=1..8 carries data LSB first, n=9 odd parity, n=10 stop (released line)
   always_comb begin
      tx_bit = 1'b1;
      if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd8) begin
         tx_bit = tx_byte_q[bit_cnt_q[2:0] - 3'd1];
      end else if (bit_cnt_q == 4'd9) begin
         tx_bit = ~^tx_byte_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         tx_byte_q   <= '0;
         mask_q      <= '0;
         pend_q      <= 1'b0;
         pend_mask_q <= '0;
         retry_q     <= '0;
         clk_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_byte_q   <= tx_byte_d;
         mask_q      <= mask_d;
         pend_q      <= pend_d;
         pend_mask_q <= pend_mask_d;
         retry_q     <= retry_d;
         clk_prev_q  <= clk_sync;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_cnt_d   = bit_cnt_q;
      tx_byte_d   = tx_byte_q;
      mask_d      = mask_q;
      pend_d      = pend_q;
      pend_mask_d = pend_mask_q;
      retry_d     = retry_q;
      start       = 1'b0;
      start_mask  = led_mask;
      busy        = 1'b1;
      done        = 1'b0;
      err         = 1'b0;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      rx_hold     = 1'b0;

      if (led_req && state_q != S_IDLE) begin
         pend_d      = 1'b1;
         pend_mask_d = led_mask;
      end

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (led_req) begin
               start = 1'b1;
            end
         end
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            rx_hold    = 1'b1;
            if (cnt_q >= INH_LAST) begin
               state_d = S_RTS;
            end
         end
         S_RTS: begin
            ps2_data_oe = 1'b1;
            rx_hold     = 1'b1;
            if (fall) begin
               state_d   = S_TX;
               bit_cnt_d = 4'd1;
            end else if (cnt_q >= TMO_LAST) begin
               state_d = S_ERR;
            end
         end
         S_TX: begin
            ps2_data_oe = ~tx_bit;
            rx_hold     = 1'b1;
            if (fall) begin
               if (bit_cnt_q == 4'd10) begin
                  state_d = data_sync ? S_ERR : S_WAIT_ACK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (cnt_q >= TMO_LAST) begin
               state_d = S_ERR;
            end
         end
         S_WAIT_ACK: begin
            if (rx_valid) begin
               if (rx_byte == RSP_ACK) begin
                  if (tx_byte_q == CMD_LED) begin
                     tx_byte_d = {5'b0, mask_q};
                     retry_d   = '0;
                     state_d   = S_INHIBIT;
                  end else begin
                     state_d = S_DONE;
                  end
               end else if (rx_byte == RSP_RESEND && retry_q < RETRY_LIM) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_INHIBIT;
               end else begin
                  state_d = S_ERR;
               end
            end else if (cnt_q >= TMO_LAST) begin
               state_d = S_ERR;
            end
         end
         S_DONE, S_ERR: begin
            done    = (state_q == S_DONE);
            err     = (state_q == S_ERR);
            state_d = S_IDLE;
            // A request arriving this very cycle is newer than anything already queued
            if (led_req) begin
               start = 1'b1;
               pend_d = 1'b0;
            end else if (pend_q) begin
               start      = 1'b1;
               start_mask = pend_mask_q;
               pend_d     = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (start) begin
         state_d   = S_INHIBIT;
         mask_d    = start_mask;
         tx_byte_d = CMD_LED;
         retry_d   = '0;
      end

      if (state_d != state_q || state_q == S_IDLE || (state_q == S_TX && fall)) begin
         cnt_d = '0;
      end
   end

endmodule
